bus_timer: RTL and testbench

//  Memory-mapped 32-bit timer; a responder on the CPU data-memory bus (ce/we/addr/sel/data).

---
 rtl/bus_timer_pkg.sv | 28 ++
 rtl/bus_timer_prescaler.sv | 26 ++
 rtl/bus_timer.sv | 116 +++++++++++
 tb/tb_bus_timer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped bus timer: register indices, CTRL bit positions,
// window size and the byte-lane merge helper.
package bus_timer_pkg;

  localparam int unsigned TimerWinBits = 5;

  // Register index = addr[4:2]
  localparam logic [2:0] TimerCtrlOff   = 3'd0;
  localparam logic [2:0] TimerCountOff  = 3'd1;
  localparam logic [2:0] TimerCmpOff    = 3'd2;
  localparam logic [2:0] TimerStatusOff = 3'd3;
  localparam logic [2:0] TimerPrescOff  = 3'd4;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlAutoBit  = 1;
  localparam int unsigned CtrlIrqEnBit = 2;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescale counter for the bus timer: tick when the count equals presc, then restart.
// Held at zero while the timer is disabled or when presc is rewritten.
module bus_timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] presc,
  output logic        tick
);

  logic [15:0] r_pc;

  assign tick = (r_pc == presc);

  always_ff @(posedge clk) begin
    if (!rst || !en || clr) begin
      r_pc <= '0;
    end else if (tick) begin
      r_pc <= '0;
    end else begin
      r_pc <= r_pc + 16'd1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer with compare match, sticky status and level IRQ.
// Optional prescaler is built only when TIMER_PRESCALE_EN is defined.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o
);

  logic [2:0]  r_ctrl;
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_match;

  logic        w_hit;
  logic        w_wr;
  logic [2:0]  w_idx;
  logic        w_ptick;
  logic        w_tick;
  logic        w_cmp_eq;
  logic        w_match_set;
  logic        w_match_clr;
  logic [31:0] w_count_d;
  logic        w_unused;

  assign w_unused    = ^addr[1:0];
  assign w_hit       = ce & (addr[31:TimerWinBits] == BASE_ADDR[31:TimerWinBits]);
  assign w_wr        = w_hit & we;
  assign w_idx       = addr[4:2];
  assign w_tick      = r_ctrl[CtrlEnBit] & w_ptick;
  assign w_cmp_eq    = (r_count == r_cmp);
  assign w_match_set = w_tick & w_cmp_eq;
  assign w_match_clr = w_wr & (w_idx == TimerStatusOff) & sel[0] & data_i[0];
  assign irq_o       = r_match & r_ctrl[CtrlIrqEnBit];

`ifdef TIMER_PRESCALE_EN
  logic [15:0] r_presc;
  logic        w_presc_wr;

  assign w_presc_wr = w_wr & (w_idx == TimerPrescOff);

  bus_timer_prescaler u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (r_ctrl[CtrlEnBit]),
    .clr   (w_presc_wr),
    .presc (r_presc),
    .tick  (w_ptick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_presc_wr) begin
      if (sel[0]) r_presc[7:0]  <= data_i[7:0];
      if (sel[1]) r_presc[15:8] <= data_i[15:8];
    end
  end
`else
  assign w_ptick = 1'b1;
`endif

  // A CPU write to COUNT wins over the tick update in the same cycle.
  always_comb begin
    w_count_d = r_count;
    if (w_wr && (w_idx == TimerCountOff)) begin
      w_count_d = lane_merge(r_count, data_i, sel);
    end else if (w_tick) begin
      w_count_d = (w_cmp_eq && r_ctrl[CtrlAutoBit]) ? 32'd0 : r_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ctrl  <= '0;
      r_count <= '0;
      r_cmp   <= '0;
      r_match <= 1'b0;
    end else begin
      if (w_wr && (w_idx == TimerCtrlOff) && sel[0]) begin
        r_ctrl <= data_i[2:0];
      end
      if (w_wr && (w_idx == TimerCmpOff)) begin
        r_cmp <= lane_merge(r_cmp, data_i, sel);
      end
      r_count <= w_count_d;
      r_match <= w_match_set | (r_match & ~w_match_clr);
    end
  end

  always_comb begin
    data_o = '0;
    if (w_hit && !we) begin
      case (w_idx)
        TimerCtrlOff:   data_o = {29'd0, r_ctrl};
        TimerCountOff:  data_o = r_count;
        TimerCmpOff:    data_o = r_cmp;
        TimerStatusOff: data_o = {31'd0, r_match};
`ifdef TIMER_PRESCALE_EN
        TimerPrescOff:  data_o = {16'd0, r_presc};
`endif
        default:        data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: vector table, hand-written corner sequences and a
// randomized run against a behavioural model. Honours TIMER_PRESCALE_EN when defined.
module tb_bus_timer;

  localparam logic [31:0] Base = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq_o;

  int n_pass  = 0;
  int n_total = 0;

  bus_timer #(.BASE_ADDR(Base)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .sel    (sel),
    .data_i (data_i),
    .data_o (data_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_ctrl, m_count, m_cmp, m_presc;
  logic        m_match;
  int unsigned m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a / 32 != Base / 32) return 32'd0;
    case ((a % 32) / 4)
      0: return m_ctrl;
      1: return m_count;
      2: return m_cmp;
      3: return {31'd0, m_match};
      4: return m_presc;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    bit hit, wr, tick, set, clr;
    int unsigned off, pc_n;
    logic [31:0] cnt_n;
    if (rst !== 1'b1) begin
      m_ctrl = 0; m_count = 0; m_cmp = 0; m_presc = 0; m_match = 0; m_pc = 0;
      return;
    end
    hit  = ce && (addr / 32 == Base / 32);
    wr   = hit && we;
    off  = (addr % 32) / 4;
    tick = m_ctrl[0] && (m_pc == m_presc);
    set  = tick && (m_count == m_cmp);
    cnt_n = m_count;
    if (tick) cnt_n = (set && m_ctrl[1]) ? 32'd0 : m_count + 1;
    pc_n = 0;
`ifdef TIMER_PRESCALE_EN
    if (m_ctrl[0] && !(wr && off == 4) && !tick) pc_n = (m_pc + 1) % 65536;
`endif
    clr = wr && off == 3 && sel[0] && data_i[0];
    if (wr) begin
      case (off)
        0: m_ctrl  = merge(m_ctrl, data_i, sel) & 32'h7;
        1: cnt_n   = merge(m_count, data_i, sel);
        2: m_cmp   = merge(m_cmp, data_i, sel);
`ifdef TIMER_PRESCALE_EN
        4: m_presc = merge(m_presc, data_i, sel) & 32'hFFFF;
`endif
        default: ;
      endcase
    end
    m_count = cnt_n;
    m_match = set || (m_match && !clr);
    m_pc    = pc_n;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic c, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic [31:0] exp, input string name);
    ce = c; we = w; addr = a; sel = s; data_i = d;
    #1;
    chk(name, data_o, exp);
    step();
    ce = 0; we = 0; addr = 0; sel = 0; data_i = 0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    acc(1'b1, 1'b1, Base + off, s, d, 32'd0, "write data_o");
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
    acc(1'b1, 1'b0, Base + off, 4'h0, 32'd0, exp, name);
  endtask

  task automatic reset_dut();
    rst = 0;
    step();
    rst = 1;
  endtask

  typedef struct {
    logic        c;
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] presc_exp;
  logic [31:0] seq[$];

  initial begin
    rst = 0; ce = 0; we = 0; addr = 0; sel = 0; data_i = 0;
`ifdef TIMER_PRESCALE_EN
    presc_exp = 32'h0000_5678;
`else
    presc_exp = 32'd0;
`endif

    // Reset while running
    step(); step();
    rst = 1;
    wr(32'h00, 32'h7, 4'hF);
    step(); step();
    chk("running irq before reset", {31'd0, irq_o}, 32'd1);
    rst = 0;
    step(); step();
    rst = 1;
    #1;
    chk("reset irq", {31'd0, irq_o}, 32'd0);
    chk("reset idle data_o", data_o, 32'd0);
    rd(32'h00, 0, "reset CTRL");
    rd(32'h04, 0, "reset COUNT");
    rd(32'h08, 0, "reset CMP");
    rd(32'h0C, 0, "reset STATUS");
    rd(32'h10, 0, "reset PRESC");

    // Vector table: lanes, decode, reserved offsets (counter stays disabled)
    tbl.push_back('{1, 1, Base + 32'h08, 4'hF, 32'h0,         32'h0});
    tbl.push_back('{1, 1, Base + 32'h08, 4'h5, 32'hAABBCCDD,  32'h0});
    tbl.push_back('{1, 0, Base + 32'h08, 4'h0, 32'h0,         32'h00BB00DD});
    tbl.push_back('{1, 1, Base + 32'h00, 4'h1, 32'hFFFFFFF6,  32'h0});
    tbl.push_back('{1, 0, Base + 32'h00, 4'hF, 32'h0,         32'h6});
    tbl.push_back('{1, 1, Base + 32'h04, 4'hC, 32'h11223344,  32'h0});
    tbl.push_back('{1, 0, Base + 32'h04, 4'hF, 32'h0,         32'h11220000});
    tbl.push_back('{1, 1, Base + 32'h14, 4'hF, 32'hDEADBEEF,  32'h0});
    tbl.push_back('{1, 0, Base + 32'h14, 4'hF, 32'h0,         32'h0});
    tbl.push_back('{1, 0, Base + 32'h1C, 4'hF, 32'h0,         32'h0});
    tbl.push_back('{1, 1, Base + 32'h10, 4'hF, 32'h12345678,  32'h0});
    tbl.push_back('{1, 0, Base + 32'h10, 4'hF, 32'h0,         presc_exp});
    tbl.push_back('{1, 1, Base + 32'h28, 4'hF, 32'h1,         32'h0});
    tbl.push_back('{0, 1, Base + 32'h08, 4'hF, 32'h2,         32'h0});
    tbl.push_back('{1, 0, Base + 32'h08, 4'hF, 32'h0,         32'h00BB00DD});
    tbl.push_back('{1, 0, Base + 32'h28, 4'hF, 32'h0,         32'h0});
    tbl.push_back('{0, 0, Base + 32'h08, 4'hF, 32'h0,         32'h0});
    tbl.push_back('{1, 0, Base + 32'h0C, 4'hF, 32'h0,         32'h0});
    tbl.push_back('{1, 0, Base + 32'h0B, 4'hF, 32'h0,         32'h00BB00DD});
    tbl.push_back('{1, 1, Base + 32'h00, 4'hF, 32'h0,         32'h0});
    for (int i = 0; i < tbl.size(); i++) begin
      acc(tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].exp,
          $sformatf("vec%0d", i));
    end

    // Match with auto-reload, W1C, second match
    reset_dut();
    wr(32'h08, 32'd5, 4'hF);
    wr(32'h00, 32'h7, 4'hF);
    for (int k = 0; k <= 5; k++) begin
      chk("t3 irq low", {31'd0, irq_o}, 32'd0);
      rd(32'h04, k, "t3 count");
    end
    chk("t3 irq first match", {31'd0, irq_o}, 32'd1);
    rd(32'h04, 32'd0, "t3 reload");
    rd(32'h0C, 32'd1, "t3 status");
    wr(32'h0C, 32'd1, 4'h1);
    chk("t3 irq cleared", {31'd0, irq_o}, 32'd0);
    for (int k = 3; k <= 5; k++) rd(32'h04, k, "t3 count2");
    chk("t3 irq second match", {31'd0, irq_o}, 32'd1);
    rd(32'h04, 32'd0, "t3 reload2");

    // Same-cycle collisions
    wr(32'h04, 32'd100, 4'hF);
    rd(32'h04, 32'd100, "t4 count write wins");
    wr(32'h0C, 32'd1, 4'h1);
    chk("t4 irq cleared", {31'd0, irq_o}, 32'd0);
    wr(32'h04, 32'd5, 4'hF);
    wr(32'h0C, 32'd1, 4'h1);
    chk("t4 irq set beats clear", {31'd0, irq_o}, 32'd1);
    rd(32'h0C, 32'd1, "t4 status set beats clear");

    // Wrap without reload, then decode
    wr(32'h00, 32'd0, 4'hF);
    wr(32'h0C, 32'd1, 4'h1);
    wr(32'h04, 32'hFFFF_FFFE, 4'hF);
    wr(32'h08, 32'd3, 4'hF);
    wr(32'h00, 32'h5, 4'hF);
    seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3};
    foreach (seq[k]) begin
      chk("t5 irq low", {31'd0, irq_o}, 32'd0);
      rd(32'h04, seq[k], "t5 count");
    end
    chk("t5 irq match", {31'd0, irq_o}, 32'd1);
    rd(32'h04, 32'd4, "t5 no reload");
    wr(32'h00, 32'd0, 4'hF);
    acc(1'b1, 1'b1, Base + 32'h20, 4'hF, 32'hFF, 32'd0, "t5 outside write");
    acc(1'b0, 1'b1, Base + 32'h08, 4'hF, 32'hFF, 32'd0, "t5 ce0 write");
    acc(1'b1, 1'b0, Base + 32'h20, 4'hF, 32'd0, 32'd0, "t5 outside read");
    rd(32'h08, 32'd3, "t5 cmp untouched");

    // Prescaler
    reset_dut();
`ifdef TIMER_PRESCALE_EN
    wr(32'h10, 32'd3, 4'hF);
    wr(32'h00, 32'd1, 4'hF);
    for (int i = 0; i < 12; i++) rd(32'h04, i / 4, "t6 prescaled count");
`else
    wr(32'h10, 32'hFFFF_FFFF, 4'hF);
    rd(32'h10, 32'd0, "t6 presc absent");
`endif

    // Randomized run against the model
    reset_dut();
    for (int n = 0; n < 800; n++) begin
      int unsigned op;
      logic [31:0] a, d;
      op = $urandom_range(0, 19);
      chk("rnd irq", {31'd0, irq_o}, {31'd0, m_match && m_ctrl[2]});
      if (op < 8) begin
        a = Base + $urandom_range(0, 31);
        acc(1'b1, 1'b0, a, 4'($urandom), 32'd0, model_read(a), "rnd read");
      end else if (op < 17) begin
        a = Base + 4 * $urandom_range(0, 5) + $urandom_range(0, 3);
        d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 12);
        acc(1'b1, 1'b1, a, 4'($urandom), d, 32'd0, "rnd write");
      end else if (op < 19) begin
        a = $urandom_range(0, 1) ? Base + 32'h20 + $urandom_range(0, 31) : Base + 32'h4;
        acc(1'(a >= Base + 32'h20), 1'($urandom), a, 4'hF, $urandom, 32'd0, "rnd miss");
      end else begin
        rst = 0;
        acc(1'b1, 1'b1, Base + 32'h4, 4'hF, $urandom, 32'd0, "rnd reset write");
        rst = 1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
